// File: rtl/layer_pkg.sv
// Shared types and default geometry for the layer output serializer.
package layer_pkg;

  localparam int unsigned DATA_WIDHT = 32;
  localparam int unsigned CHANNEL    = 8;
  localparam int unsigned CH_IDX_W   = $clog2(CHANNEL);

  // One packed input beat: channel k lives in bits [DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k].
  typedef logic [DATA_WIDHT*CHANNEL-1:0] beat_t;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } rd_state_e;

endpackage

// File: rtl/packed_word_fifo.sv
// Synchronous FIFO of packed beats with a show-ahead head and an occupancy count.
// The caller decides when a write is legal; a write into a full FIFO is only
// honoured when a pop happens on the same edge.
module packed_word_fifo #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign do_rd = rd_en_i && (count_q != '0);
  assign do_wr = wr_en_i && ((count_q != FullCnt) || do_rd);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since reads are qualified by occupancy.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == FullCnt);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/layer_output_serializer.sv
// Serializes packed multi-channel beats into one channel word per transfer,
// flagging the last word of each pixel and, optionally, of each frame.
// Optional frame tracking (pixel counter and Frame_Last) is enabled by defining
// LAYER_SER_FRAME_TRACK_EN; otherwise Frame_Last is tied low.
module layer_output_serializer #(
  parameter int unsigned DATA_WIDHT = layer_pkg::DATA_WIDHT,
  parameter int unsigned CHANNEL    = layer_pkg::CHANNEL,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OUT_WIDTH  = 218,
  parameter int unsigned OUT_HEIGHT = 218
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
  input  logic                          Valid_In,
  input  logic                          Ready_In,
  output logic [DATA_WIDHT-1:0]         Data_Out,
  output logic [$clog2(CHANNEL)-1:0]    Channel_Out,
  output logic                          Valid_Out,
  output logic                          Pixel_Last,
  output logic                          Frame_Last,
  output logic                          Overflow
);

  import layer_pkg::*;

  localparam int unsigned BeatW  = DATA_WIDHT * CHANNEL;
  localparam int unsigned ChIdxW = $clog2(CHANNEL);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NumPix = OUT_WIDTH * OUT_HEIGHT;
  localparam logic [ChIdxW-1:0] LastCh = ChIdxW'(CHANNEL - 1);

  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic [BeatW-1:0] head;

  logic wr_accept, pop, xfer, valid, pixel_last;
  logic [DATA_WIDHT-1:0] data_sel;

  rd_state_e state_q, state_d;
  logic [ChIdxW-1:0] ch_q, ch_d;
  logic ovf_q, ovf_d;

  assign valid     = (state_q == StSend) && !fifo_empty;
  assign xfer      = valid && Ready_In;
  assign pop       = xfer && (ch_q == LastCh);
  // A full FIFO still takes a beat when the head leaves on the same edge.
  assign wr_accept = Valid_In && (!fifo_full || pop);

  packed_word_fifo #(
    .Width (BeatW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_accept),
    .wr_data_i (Data_In),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Read-control FSM: leave SEND only when the last beat pops with nothing arriving.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (wr_accept) state_d = StSend;
      StSend:  if (pop && !wr_accept && (fifo_count == CntW'(1))) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Channel counter and sticky overflow next-state.
  always_comb begin
    ch_d  = ch_q;
    ovf_d = ovf_q | (Valid_In && fifo_full && !pop);
    if (xfer) ch_d = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
  end

  // Read-side state with synchronous reset; reset drops any partial beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
    end
  end

  // Select the current channel word out of the head beat.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      if (ch_q == ChIdxW'(k)) data_sel = head[k*DATA_WIDHT +: DATA_WIDHT];
    end
  end

  assign pixel_last  = valid && (ch_q == LastCh);
  assign Valid_Out   = valid;
  assign Data_Out    = valid ? data_sel : '0;
  assign Channel_Out = ch_q;
  assign Pixel_Last  = pixel_last;
  assign Overflow    = ovf_q;

`ifdef LAYER_SER_FRAME_TRACK_EN
  localparam int unsigned PixW = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam logic [PixW-1:0] LastPix = PixW'(NumPix - 1);

  logic [PixW-1:0] pix_q, pix_d;

  // Pixel counter advances once per popped beat and wraps at the frame size.
  always_comb begin
    pix_d = pix_q;
    if (pop) pix_d = (pix_q == LastPix) ? '0 : pix_q + 1'b1;
  end

  // Pixel counter register.
  always_ff @(posedge clk) begin
    if (rst) pix_q <= '0;
    else     pix_q <= pix_d;
  end

  assign Frame_Last = pixel_last && (pix_q == LastPix);
`else
  logic unused_num_pix;
  assign unused_num_pix = ^NumPix;
  assign Frame_Last     = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with a 2x2 frame so frame wrap is reachable.
`timescale 1ns/1ps
module tb_layer_output_serializer;
  import layer_pkg::*;

`ifdef LAYER_SER_FRAME_TRACK_EN
  localparam bit FrameTrack = 1'b1;
`else
  localparam bit FrameTrack = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  beat_t                 Data_In = '0;
  logic                  Valid_In = 1'b0;
  logic                  Ready_In = 1'b0;
  logic [DATA_WIDHT-1:0] Data_Out;
  logic [CH_IDX_W-1:0]   Channel_Out;
  logic                  Valid_Out, Pixel_Last, Frame_Last, Overflow;

  int n_cmp = 0;
  int n_err = 0;
  int pix_model = 0;  // beats popped since reset, modulo the 4-pixel frame

  layer_output_serializer #(
    .DATA_WIDHT (DATA_WIDHT),
    .CHANNEL    (CHANNEL),
    .FIFO_DEPTH (4),
    .OUT_WIDTH  (2),
    .OUT_HEIGHT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Data_In     (Data_In),
    .Valid_In    (Valid_In),
    .Ready_In    (Ready_In),
    .Data_Out    (Data_Out),
    .Channel_Out (Channel_Out),
    .Valid_Out   (Valid_Out),
    .Pixel_Last  (Pixel_Last),
    .Frame_Last  (Frame_Last),
    .Overflow    (Overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int id, input int c);
    return 32'h3F80_0000 + 32'(c) + 32'(id) * 32'd256;
  endfunction

  function automatic beat_t mk_beat(input int id);
    beat_t b;
    for (int c = 0; c < CHANNEL; c++) b[c*DATA_WIDHT +: DATA_WIDHT] = exp_word(id, c);
    return b;
  endfunction

  function automatic logic exp_fl(input int c);
    return FrameTrack && (c == 7) && (pix_model == 3);
  endfunction

  task automatic do_reset();
    rst = 1'b1; Valid_In = 1'b0; Ready_In = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pix_model = 0;
  endtask

  task automatic send_beat(input int id);
    Valid_In = 1'b1;
    Data_In  = mk_beat(id);
    @(posedge clk); #1;
    Valid_In = 1'b0;
    Data_In  = '0;
  endtask

  task automatic fill(input int first_id, input int n, input int drop_from);
    Ready_In = 1'b0;
    for (int i = 0; i < n; i++) begin
      Valid_In = 1'b1;
      Data_In  = mk_beat(first_id + i);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("overflow_fill", Overflow, i >= drop_from);
    end
    Valid_In = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drain nbeats consecutive beats; in stall mode Ready_In alternates 1,0,1,0.
  task automatic drain(input int first_id, input int nbeats, input bit stall);
    int w, cyc, id, c;
    w = 0; cyc = 0;
    while (w < nbeats * 8 && cyc < 400) begin
      Ready_In = stall ? (cyc % 2 == 0) : 1'b1;
      id = first_id + w / 8;
      c  = w % 8;
      @(negedge clk);
      check_eq("valid", Valid_Out, 1'b1);
      check_eq("data", Data_Out, exp_word(id, c));
      check_eq("chan", Channel_Out, c);
      check_eq("pixel_last", Pixel_Last, c == 7);
      check_eq("frame_last", Frame_Last, exp_fl(c));
      if (Ready_In && Valid_Out) begin
        w++;
        if (c == 7) pix_model = (pix_model + 1) % 4;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (w != nbeats * 8) check_eq("drain_timeout", w, nbeats * 8);
    Ready_In = 1'b0;
    @(negedge clk);
    check_eq("drained_empty", Valid_Out, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check_eq("rst_valid", Valid_Out, 1'b0);
    check_eq("rst_data", Data_Out, 0);
    check_eq("rst_chan", Channel_Out, 0);
    check_eq("rst_pixel_last", Pixel_Last, 1'b0);
    check_eq("rst_frame_last", Frame_Last, 1'b0);
    check_eq("rst_overflow", Overflow, 1'b0);
    @(posedge clk); #1;

    // Single beat, continuous ready; Valid_Out must be low until the write edge.
    Valid_In = 1'b1;
    Data_In  = mk_beat(0);
    @(negedge clk);
    check_eq("pre_write_valid", Valid_Out, 1'b0);
    @(posedge clk); #1;
    Valid_In = 1'b0;
    drain(0, 1, 1'b0);

    // Ready toggling mid-beat.
    send_beat(1);
    drain(1, 1, 1'b1);

    // Six beats into a 4-deep FIFO with no ready: last two dropped, overflow sticky.
    fill(2, 6, 4);
    drain(2, 4, 1'b0);
    check_eq("overflow_sticky", Overflow, 1'b1);

    // Full FIFO with a pop and a write on the same edge.
    do_reset();
    fill(8, 4, 4);
    Ready_In = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_eq("fp_chan", Channel_Out, i);
      check_eq("fp_data", Data_Out, exp_word(8, i));
      @(posedge clk); #1;
    end
    Valid_In = 1'b1;
    Data_In  = mk_beat(12);
    @(negedge clk);
    check_eq("fp_last_chan", Channel_Out, 7);
    check_eq("fp_pixel_last", Pixel_Last, 1'b1);
    check_eq("fp_frame_last", Frame_Last, exp_fl(7));
    @(posedge clk); #1;
    Valid_In = 1'b0;
    pix_model = (pix_model + 1) % 4;
    drain(9, 4, 1'b0);
    check_eq("fp_overflow", Overflow, 1'b0);

    // Five single beats: the frame closes on the 32nd word, the 5th beat starts over.
    do_reset();
    for (int b = 0; b < 5; b++) begin
      send_beat(20 + b);
      drain(20 + b, 1, 1'b0);
    end

    // Reset after three words of a beat, with Valid_In high during reset.
    send_beat(30);
    Ready_In = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_chan", Channel_Out, i);
      @(posedge clk); #1;
    end
    rst = 1'b1; Valid_In = 1'b1; Data_In = mk_beat(99);
    @(posedge clk); #1;
    rst = 1'b0; Valid_In = 1'b0; Data_In = '0;
    pix_model = 0;
    @(negedge clk);
    check_eq("mr_valid", Valid_Out, 1'b0);
    check_eq("mr_data", Data_Out, 0);
    check_eq("mr_chan", Channel_Out, 0);
    check_eq("mr_pixel_last", Pixel_Last, 1'b0);
    check_eq("mr_frame_last", Frame_Last, 1'b0);
    check_eq("mr_overflow", Overflow, 1'b0);
    @(posedge clk); #1;
    send_beat(31);
    drain(31, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
